// File: rtl/alu181_pkg.sv
// alu181_pkg: shared types and limits for the 74181 ALU scheduler
package alu181_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} sched_state_e;
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       m;
  } alu_op_t;
  localparam int SETTLE_MAX = 15;
endpackage

// File: rtl/alu181_sched_arb.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr+1
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id
);
  logic [IW-1:0] w_idx;
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    w_idx  = '0;
    // walk from lowest to highest priority so the nearest requester wins last
    for (int k = N; k >= 1; k--) begin
      w_idx = IW'((int'(ptr) + k) % N);
      if (en && req[w_idx]) begin
        gnt        = '0;
        gnt[w_idx] = 1'b1;
        gnt_id     = w_idx;
      end
    end
  end
endmodule

// File: rtl/alu181_sched.sv
// alu181_sched: round-robin sharing of one 74181 ALU between NREQ requesters
module alu181_sched
  import alu181_pkg::*;
#(
  parameter  int NREQ       = 2,
  parameter  int SETTLE_CYC = 1,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0][3:0] req_a,
  input  logic [NREQ-1:0][3:0] req_b,
  input  logic [NREQ-1:0][3:0] req_s,
  input  logic [NREQ-1:0]      req_m,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_s,
  output logic                 alu_m,
  input  logic [4:0]           alu_f,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [4:0]           rsp_f,
  output logic                 busy
);
  localparam logic [3:0] LOAD = 4'((SETTLE_CYC > SETTLE_MAX) ? SETTLE_MAX :
                                   (SETTLE_CYC < 1) ? 1 : SETTLE_CYC);
  sched_state_e   r_state, w_next;
  alu_op_t        r_op;
  logic [3:0]     r_cnt;
  logic [IDW-1:0] r_ptr, r_id, w_gid;
  logic [4:0]     r_f;
  logic [NREQ-1:0] w_gnt;
  logic           w_hs;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (r_ptr),
    .en    (r_state == IDLE && !rst),
    .gnt   (w_gnt),
    .gnt_id(w_gid)
  );

  assign req_ready = w_gnt;
  assign w_hs      = |w_gnt;
  assign alu_a     = r_op.a;
  assign alu_b     = r_op.b;
  assign alu_s     = r_op.s;
  assign alu_m     = r_op.m;
  assign rsp_valid = r_state == RESP;
  assign rsp_id    = r_id;
  assign rsp_f     = r_f;
  assign busy      = r_state != IDLE;

  always_comb begin
    w_next = (r_state == IDLE && w_hs)           ? SETTLE :
             (r_state == SETTLE && r_cnt == 4'd1) ? RESP   :
             (r_state == RESP && rsp_ready)       ? IDLE   : r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_id    <= '0;
      r_f     <= '0;
      r_cnt   <= '0;
      r_ptr   <= IDW'(NREQ - 1);
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_op  <= '{a: req_a[w_gid], b: req_b[w_gid], s: req_s[w_gid], m: req_m[w_gid]};
        r_id  <= w_gid;
        r_cnt <= LOAD;
      end
      if (r_state == SETTLE) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) r_f <= alu_f;
      end
      if (r_state == RESP && rsp_ready) r_ptr <= r_id;
    end
  end
endmodule

// File: tb/tb_alu181_sched.sv
// tb_alu181_sched: randomized self-checking bench with a 74181 model attached to the ALU ports
module tb_alu181_sched;
  localparam int N = 2;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid = '0, req_m = '0;
  logic [N-1:0][3:0] req_a = '0, req_b = '0, req_s = '0;
  logic rsp_ready = 0;
  logic [N-1:0] req_ready, req_ready4;
  logic [3:0] alu_a, alu_b, alu_s, alu_a4, alu_b4, alu_s4;
  logic alu_m, alu_m4, rsp_valid, rsp_valid4, busy, busy4;
  logic [4:0] alu_f, alu_f4, rsp_f, rsp_f4;
  logic [0:0] rsp_id, rsp_id4;
  int n_checks = 0, n_pass = 0, last = N - 1;

  always #5 clk = ~clk;

  function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s, input logic m);
    logic [3:0] x, y;
    x = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    y = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    return m ? {1'b0, ~(x ^ y)} : {1'b0, x} + {1'b0, y};
  endfunction

  function automatic int next_grant(input logic [N-1:0] v, input int from);
    for (int k = 1; k <= N; k++) if (v[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    return (g < 0) ? '0 : N'(1 << g);
  endfunction

  assign alu_f  = alu_ref(alu_a, alu_b, alu_s, alu_m);
  assign alu_f4 = alu_ref(alu_a4, alu_b4, alu_s4, alu_m4);

  alu181_sched #(.NREQ(N), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_f(alu_f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_f(rsp_f), .busy(busy));

  alu181_sched #(.NREQ(N), .SETTLE_CYC(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4),
    .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_s(alu_s4), .alu_m(alu_m4), .alu_f(alu_f4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_id(rsp_id4), .rsp_f(rsp_f4), .busy(busy4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i] = 4'($urandom);
      req_b[i] = 4'($urandom);
      req_s[i] = 4'($urandom);
      req_m[i] = 1'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    req_valid = 2'b11;
    step();
    step();
    n_checks++; if (req_ready !== 2'b00) $display("FAIL reset_ready got %b want 00", req_ready); else n_pass++;
    n_checks++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL reset_flags got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy); else n_pass++;
    n_checks++; if ({alu_a, alu_b, alu_s, alu_m} !== 13'd0) $display("FAIL reset_alu got %h %h %h %b want 0", alu_a, alu_b, alu_s, alu_m); else n_pass++;
    n_checks++; if ({rsp_id, rsp_f} !== 6'd0) $display("FAIL reset_rsp got id=%0d f=%h want 0", rsp_id, rsp_f); else n_pass++;
    req_valid = '0;
    rst = 0;
    last = N - 1;
  endtask

  task automatic test_single();
    logic [4:0] ef;
    req_a[0] = 4'd3; req_b[0] = 4'd6; req_s[0] = 4'd0; req_m[0] = 1'b0;
    ef = alu_ref(4'd3, 4'd6, 4'd0, 1'b0);
    req_valid = 2'b01;
    rsp_ready = 1;
    #1;
    n_checks++; if (req_ready !== 2'b01) $display("FAIL single_grant got %b want 01", req_ready); else n_pass++;
    step();
    req_valid = '0;
    n_checks++; if ({alu_a, alu_b, alu_s, alu_m} !== {4'd3, 4'd6, 4'd0, 1'b0}) $display("FAIL single_alu got %h %h %h %b want 3 6 0 0", alu_a, alu_b, alu_s, alu_m); else n_pass++;
    n_checks++; if ({rsp_valid, busy} !== 2'b01) $display("FAIL single_settle got rsp_valid=%b busy=%b want 0 1", rsp_valid, busy); else n_pass++;
    step();
    n_checks++; if ({rsp_valid, rsp_id, rsp_f} !== {1'b1, 1'b0, ef}) $display("FAIL single_rsp got v=%b id=%0d f=%h want 1 0 %h", rsp_valid, rsp_id, rsp_f, ef); else n_pass++;
    step();
    n_checks++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL single_done got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy); else n_pass++;
    last = 0;
  endtask

  task automatic test_contention();
    int g;
    logic [4:0] ef;
    rst = 1;
    step();
    rst = 0;
    last = N - 1;
    rand_ops();
    req_valid = 2'b11;
    rsp_ready = 1;
    for (int op = 0; op < 8; op++) begin
      g = next_grant(req_valid, last);
      ef = alu_ref(req_a[g], req_b[g], req_s[g], req_m[g]);
      #1;
      n_checks++; if (req_ready !== onehot(g)) $display("FAIL contention_grant op %0d got %b want %b", op, req_ready, onehot(g)); else n_pass++;
      step();
      step();
      n_checks++; if ({rsp_valid, rsp_id, rsp_f} !== {1'b1, 1'(g), ef}) $display("FAIL contention_rsp op %0d got v=%b id=%0d f=%h want 1 %0d %h", op, rsp_valid, rsp_id, rsp_f, g, ef); else n_pass++;
      step();
      last = g;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int g;
    logic [4:0] e0, e1;
    rand_ops();
    e0 = alu_ref(req_a[0], req_b[0], req_s[0], req_m[0]);
    e1 = alu_ref(req_a[1], req_b[1], req_s[1], req_m[1]);
    req_valid = 2'b01;
    rsp_ready = 0;
    g = next_grant(req_valid, last);
    #1;
    n_checks++; if (req_ready !== onehot(g)) $display("FAIL bp_grant got %b want %b", req_ready, onehot(g)); else n_pass++;
    step();
    req_valid = 2'b10;
    step();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({rsp_valid, rsp_id, rsp_f, req_ready} !== {1'b1, 1'b0, e0, 2'b00}) $display("FAIL bp_hold cycle %0d got v=%b id=%0d f=%h rdy=%b want 1 0 %h 00", i, rsp_valid, rsp_id, rsp_f, req_ready, e0); else n_pass++;
      step();
    end
    rsp_ready = 1;
    #1;
    n_checks++; if (req_ready !== 2'b00) $display("FAIL bp_release_ready got %b want 00", req_ready); else n_pass++;
    step();
    last = 0;
    n_checks++; if (req_ready !== 2'b10) $display("FAIL bp_next_grant got %b want 10", req_ready); else n_pass++;
    step();
    req_valid = '0;
    step();
    n_checks++; if ({rsp_valid, rsp_id, rsp_f} !== {1'b1, 1'b1, e1}) $display("FAIL bp_rsp1 got v=%b id=%0d f=%h want 1 1 %h", rsp_valid, rsp_id, rsp_f, e1); else n_pass++;
    step();
    last = 1;
  endtask

  task automatic test_reset_mid();
    int n;
    logic bad;
    logic [4:0] e0;
    rst = 1;
    step();
    rst = 0;
    rand_ops();
    e0 = alu_ref(req_a[0], req_b[0], req_s[0], req_m[0]);
    rsp_ready = 1;
    req_valid = 2'b10;
    #1;
    n_checks++; if (req_ready4 !== 2'b10) $display("FAIL mid_grant got %b want 10", req_ready4); else n_pass++;
    step();
    req_valid = '0;
    n_checks++; if (busy4 !== 1'b1) $display("FAIL mid_busy got %b want 1", busy4); else n_pass++;
    step();
    rst = 1;
    step();
    rst = 0;
    n_checks++; if ({rsp_valid4, busy4, alu_a4, alu_b4} !== 10'd0) $display("FAIL mid_abort got v=%b busy=%b a=%h b=%h want 0", rsp_valid4, busy4, alu_a4, alu_b4); else n_pass++;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid4 !== 1'b0) bad = 1;
    end
    n_checks++; if (bad) $display("FAIL mid_no_rsp got a response after abort want none"); else n_pass++;
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready4 !== 2'b01) $display("FAIL mid_regrant got %b want 01", req_ready4); else n_pass++;
    step();
    req_valid = '0;
    n = 0;
    while (rsp_valid4 !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    n_checks++; if (n !== 4) $display("FAIL mid_latency got %0d cycles want 4", n); else n_pass++;
    n_checks++; if ({rsp_id4, rsp_f4} !== {1'b0, e0}) $display("FAIL mid_rsp got id=%0d f=%h want 0 %h", rsp_id4, rsp_f4, e0); else n_pass++;
  endtask

  task automatic test_sweep();
    logic [4:0] exp_q[$];
    logic [4:0] ef;
    int n;
    rst = 1;
    step();
    rst = 0;
    rsp_ready = 1;
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 16; s++) begin
        req_a[1] = 4'd3; req_b[1] = 4'd6; req_s[1] = 4'(s); req_m[1] = 1'(m);
        req_valid = 2'b10;
        #1;
        n = 0;
        while (req_ready[1] !== 1'b1 && n < 8) begin
          step();
          n++;
        end
        n_checks++; if (req_ready[1] !== 1'b1) $display("FAIL sweep_grant m=%0d s=%0d got timeout want grant", m, s); else n_pass++;
        exp_q.push_back(alu_ref(4'd3, 4'd6, 4'(s), 1'(m)));
        step();
        req_valid = '0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 8) begin
          step();
          n++;
        end
        ef = exp_q.pop_front();
        n_checks++; if ({rsp_valid, rsp_id, rsp_f} !== {1'b1, 1'b1, ef}) $display("FAIL sweep_rsp m=%0d s=%0d got v=%b id=%0d f=%h want 1 1 %h", m, s, rsp_valid, rsp_id, rsp_f, ef); else n_pass++;
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before 200000");
    $fatal(1);
  end
endmodule
